// File: rtl/inst_d.sv
// Decode stage: IF/ID register, 32-entry register file with write-first reads,
// hazard detection against a three-slot destination scoreboard, and the ID/EX bundle.
module inst_d #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_out,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [4:0]        id_dest,
    output logic [4:0]        ex_dest,
    output logic [4:0]        mem_dest,
    output logic              reg_write_f_id,
    output logic              reg_write_f_ex,
    output logic              reg_write_f_mem,
    output logic [4:0]        rs_f_id,
    output logic [4:0]        rt_f_id,
    output logic [4:0]        rd_f_id,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [5:0]        ex_opcode,
    output logic [DATA_W-1:0] ex_rs_val,
    output logic [DATA_W-1:0] ex_rt_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [31:0]       ex_pc,
    output logic              halted,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc_q, ifid_pc_d;
    logic [DATA_W-1:0] regfile_q [32];
    logic [DATA_W-1:0] regfile_d [32];

    logic              ex_valid_q, ex_valid_d;
    logic [5:0]        ex_opcode_q, ex_opcode_d;
    logic [DATA_W-1:0] ex_rs_val_q, ex_rs_val_d;
    logic [DATA_W-1:0] ex_rt_val_q, ex_rt_val_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [4:0]        ex_dest_q, ex_dest_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q, ex_mem_read_d;
    logic              ex_mem_write_q, ex_mem_write_d;
    logic [31:0]       ex_pc_q, ex_pc_d;

    logic [4:0]        exmem_dest_q, exmem_dest_d;
    logic              exmem_rw_q, exmem_rw_d;
    logic [4:0]        memwb_dest_q, memwb_dest_d;
    logic              memwb_rw_q, memwb_rw_d;

    logic              halted_q, halted_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [5:0]        op;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic              is_r, is_i, is_ldw, is_stw, is_bzjr, is_beq, is_halt, is_legal;
    logic              use_rs, use_rt;
    logic [4:0]        dec_dest;
    logic              dec_rw;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              rs_hit, rt_hit;

    assign op  = ifid_instr_q[31:26];
    assign rs  = ifid_instr_q[25:21];
    assign rt  = ifid_instr_q[20:16];
    assign rd  = ifid_instr_q[15:11];
    assign imm = ifid_instr_q[15:0];

    // R-type opcodes are the even values 0..10, I-type the odd values 1..11.
    always_comb begin
        is_r     = (op <= 6'd10) && !op[0];
        is_i     = (op <= 6'd11) && op[0];
        is_ldw   = (op == 6'd12);
        is_stw   = (op == 6'd13);
        is_bzjr  = (op == 6'd14) || (op == 6'd16);
        is_beq   = (op == 6'd15);
        is_halt  = (op == 6'd17);
        is_legal = is_r || is_i || is_ldw || is_stw || is_bzjr || is_beq || is_halt;
        use_rs   = is_r || is_i || is_ldw || is_stw || is_bzjr || is_beq;
        use_rt   = is_r || is_stw || is_beq;
        dec_dest = is_r ? rd : ((is_i || is_ldw) ? rt : 5'd0);
        dec_rw   = (is_r || is_i || is_ldw) && (dec_dest != 5'd0);
    end

    always_comb begin
        rs_f_id = (ifid_valid_q && use_rs) ? rs : 5'd0;
        rt_f_id = (ifid_valid_q && use_rt) ? rt : 5'd0;
        rd_f_id = (ifid_valid_q && is_r) ? rd : 5'd0;
    end

    // Slot flags are never set for r0, so a zeroed source field can never match.
    assign rs_hit = (ex_reg_write_q && rs_f_id == ex_dest_q) ||
                    (exmem_rw_q && rs_f_id == exmem_dest_q) ||
                    (memwb_rw_q && rs_f_id == memwb_dest_q);
    assign rt_hit = (ex_reg_write_q && rt_f_id == ex_dest_q) ||
                    (exmem_rw_q && rt_f_id == exmem_dest_q) ||
                    (memwb_rw_q && rt_f_id == memwb_dest_q);
    assign id_stall = ifid_valid_q && (rs_hit || rt_hit);

    always_comb begin
        rs_val = regfile_q[rs];
        if (wb_en && wb_addr == rs) rs_val = wb_data;
        if (rs == 5'd0) rs_val = '0;
        rt_val = regfile_q[rt];
        if (wb_en && wb_addr == rt) rt_val = wb_data;
        if (rt == 5'd0) rt_val = '0;
    end

    always_comb begin
        regfile_d = regfile_q;
        if (wb_en && wb_addr != 5'd0) regfile_d[wb_addr] = wb_data;
    end

    always_comb begin
        ifid_valid_d   = ifid_valid_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ex_valid_d     = 1'b0;
        ex_opcode_d    = 6'd0;
        ex_rs_val_d    = '0;
        ex_rt_val_d    = '0;
        ex_imm_d       = '0;
        ex_dest_d      = 5'd0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        ex_mem_write_d = 1'b0;
        ex_pc_d        = 32'd0;
        exmem_dest_d   = ex_dest_q;
        exmem_rw_d     = ex_reg_write_q;
        memwb_dest_d   = exmem_dest_q;
        memwb_rw_d     = exmem_rw_q;
        halted_d       = halted_q;
        illegal_d      = illegal_q || (ifid_valid_q && !is_legal);
        instr_cnt_d    = instr_cnt_q;
        stall_cnt_d    = stall_cnt_q;

        if (flush) begin
            ifid_valid_d = 1'b0;
        end else if (id_stall) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else begin
            if (ifid_valid_q && is_legal) begin
                ex_valid_d     = 1'b1;
                ex_opcode_d    = op;
                ex_rs_val_d    = rs_val;
                ex_rt_val_d    = rt_val;
                ex_imm_d       = {{(DATA_W-16){imm[15]}}, imm};
                ex_dest_d      = dec_dest;
                ex_reg_write_d = dec_rw;
                ex_mem_read_d  = is_ldw;
                ex_mem_write_d = is_stw;
                ex_pc_d        = ifid_pc_q;
                instr_cnt_d    = instr_cnt_q + CNT_W'(1);
                if (is_halt) halted_d = 1'b1;
            end
            // Once halted (including the HALT issuing now) nothing new enters IF/ID.
            ifid_valid_d = !halted_d;
            ifid_instr_d = instruction;
            ifid_pc_d    = pc_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q   <= 1'b0;
            ifid_instr_q   <= 32'd0;
            ifid_pc_q      <= 32'd0;
            regfile_q      <= '{default: '0};
            ex_valid_q     <= 1'b0;
            ex_opcode_q    <= 6'd0;
            ex_rs_val_q    <= '0;
            ex_rt_val_q    <= '0;
            ex_imm_q       <= '0;
            ex_dest_q      <= 5'd0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
            ex_mem_write_q <= 1'b0;
            ex_pc_q        <= 32'd0;
            exmem_dest_q   <= 5'd0;
            exmem_rw_q     <= 1'b0;
            memwb_dest_q   <= 5'd0;
            memwb_rw_q     <= 1'b0;
            halted_q       <= 1'b0;
            illegal_q      <= 1'b0;
            instr_cnt_q    <= '0;
            stall_cnt_q    <= '0;
        end else begin
            ifid_valid_q   <= ifid_valid_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            regfile_q      <= regfile_d;
            ex_valid_q     <= ex_valid_d;
            ex_opcode_q    <= ex_opcode_d;
            ex_rs_val_q    <= ex_rs_val_d;
            ex_rt_val_q    <= ex_rt_val_d;
            ex_imm_q       <= ex_imm_d;
            ex_dest_q      <= ex_dest_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
            ex_mem_write_q <= ex_mem_write_d;
            ex_pc_q        <= ex_pc_d;
            exmem_dest_q   <= exmem_dest_d;
            exmem_rw_q     <= exmem_rw_d;
            memwb_dest_q   <= memwb_dest_d;
            memwb_rw_q     <= memwb_rw_d;
            halted_q       <= halted_d;
            illegal_q      <= illegal_d;
            instr_cnt_q    <= instr_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    // ex_dest is both the issued bundle's destination and the ID/EX scoreboard slot.
    assign id_dest         = ex_dest_q;
    assign ex_dest         = ex_dest_q;
    assign mem_dest        = memwb_dest_q;
    assign reg_write_f_id  = ex_reg_write_q;
    assign reg_write_f_ex  = exmem_rw_q;
    assign reg_write_f_mem = memwb_rw_q;
    assign ex_valid        = ex_valid_q;
    assign ex_opcode       = ex_opcode_q;
    assign ex_rs_val       = ex_rs_val_q;
    assign ex_rt_val       = ex_rt_val_q;
    assign ex_imm          = ex_imm_q;
    assign ex_reg_write    = ex_reg_write_q;
    assign ex_mem_read     = ex_mem_read_q;
    assign ex_mem_write    = ex_mem_write_q;
    assign ex_pc           = ex_pc_q;
    assign halted          = halted_q;
    assign illegal_op      = illegal_q;
    assign instr_cnt       = instr_cnt_q;
    assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_inst_d.sv
// Bench for inst_d: directed vector table, hand sequences for reset/illegal/halt,
// and randomized traffic checked every cycle against an instruction-level model.
module tb_inst_d;

    logic        clk = 1'b0;
    logic        rst, flush, wb_en;
    logic [31:0] instruction, pc_out, wb_data;
    logic [4:0]  wb_addr;
    logic [4:0]  id_dest, ex_dest, mem_dest, rs_f_id, rt_f_id, rd_f_id;
    logic        reg_write_f_id, reg_write_f_ex, reg_write_f_mem, id_stall, ex_valid;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc, instr_cnt, stall_cnt;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, halted, illegal_op;

    int n_vec = 0;
    int n_err = 0;
    int stall_run = 0;

    always #5 clk = ~clk;

    inst_d dut (
        .clk(clk), .rst(rst), .instruction(instruction), .pc_out(pc_out), .flush(flush),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_dest(id_dest), .ex_dest(ex_dest), .mem_dest(mem_dest),
        .reg_write_f_id(reg_write_f_id), .reg_write_f_ex(reg_write_f_ex),
        .reg_write_f_mem(reg_write_f_mem),
        .rs_f_id(rs_f_id), .rt_f_id(rt_f_id), .rd_f_id(rd_f_id), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rs_val(ex_rs_val),
        .ex_rt_val(ex_rt_val), .ex_imm(ex_imm), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc),
        .halted(halted), .illegal_op(illegal_op), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [31:0] a, b, imm;
        logic [4:0]  dest;
        logic        rw, mr, mw;
        logic [31:0] pc;
    } bundle_t;

    logic [31:0] m_regs [32];
    logic        m_fv;
    logic [31:0] m_fi, m_fp;
    bundle_t     m_ex;
    logic [4:0]  m_pend [3];   // in-flight written registers: ID/EX, EX/MEM, MEM/WB (0 = none)
    logic        m_halt, m_ill;
    logic [31:0] m_icnt, m_scnt;

    // 0 illegal, 1 R, 2 I, 3 LDW, 4 STW, 5 BZ/JR, 6 BEQ, 7 HALT
    function automatic int kind_of(input logic [5:0] op);
        int o;
        o = int'(op);
        if (o <= 11) return (o % 2 == 0) ? 1 : 2;
        case (o)
            12: return 3;
            13: return 4;
            14, 16: return 5;
            15: return 6;
            17: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic bundle_t bubble();
        bundle_t b;
        b.valid = 0; b.op = 0; b.a = 0; b.b = 0; b.imm = 0;
        b.dest = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.pc = 0;
        return b;
    endfunction

    function automatic logic [4:0] m_rs_f();
        int k;
        k = kind_of(m_fi[31:26]);
        return (m_fv && k >= 1 && k <= 6) ? m_fi[25:21] : 5'd0;
    endfunction

    function automatic logic [4:0] m_rt_f();
        int k;
        k = kind_of(m_fi[31:26]);
        return (m_fv && (k == 1 || k == 4 || k == 6)) ? m_fi[20:16] : 5'd0;
    endfunction

    function automatic logic [4:0] m_rd_f();
        return (m_fv && kind_of(m_fi[31:26]) == 1) ? m_fi[15:11] : 5'd0;
    endfunction

    function automatic logic m_stall();
        logic [4:0] s, t;
        s = m_rs_f();
        t = m_rt_f();
        for (int i = 0; i < 3; i++)
            if (m_pend[i] != 0 && (m_pend[i] == s || m_pend[i] == t)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return m_regs[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        for (int i = 0; i < 3; i++) m_pend[i] = 0;
        m_fv = 0; m_fi = 0; m_fp = 0; m_ex = bubble();
        m_halt = 0; m_ill = 0; m_icnt = 0; m_scnt = 0;
    endtask

    task automatic m_step();
        int      k;
        logic    st;
        bundle_t nb;
        if (rst) begin
            m_reset();
            return;
        end
        k  = kind_of(m_fi[31:26]);
        st = m_stall();
        if (m_fv && k == 0) m_ill = 1;
        nb = bubble();
        if (flush) begin
            m_fv = 0;
        end else if (st) begin
            m_scnt = m_scnt + 1;
        end else begin
            if (m_fv && k != 0) begin
                nb.valid = 1;
                nb.op    = m_fi[31:26];
                nb.a     = m_read(m_fi[25:21]);
                nb.b     = m_read(m_fi[20:16]);
                nb.imm   = {{16{m_fi[15]}}, m_fi[15:0]};
                nb.dest  = (k == 1) ? m_fi[15:11] : ((k == 2 || k == 3) ? m_fi[20:16] : 5'd0);
                nb.rw    = (nb.dest != 0);
                nb.mr    = (k == 3);
                nb.mw    = (k == 4);
                nb.pc    = m_fp;
                m_icnt   = m_icnt + 1;
                if (k == 7) m_halt = 1;
            end
            m_fv = !m_halt;
            m_fi = instruction;
            m_fp = pc_out;
        end
        m_pend[2] = m_pend[1];
        m_pend[1] = m_pend[0];
        m_pend[0] = nb.rw ? nb.dest : 5'd0;
        m_ex = nb;
        if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("id_dest", 32'(id_dest), 32'(m_ex.dest));
        chk("ex_dest", 32'(ex_dest), 32'(m_ex.dest));
        chk("mem_dest", 32'(mem_dest), 32'(m_pend[2]));
        chk("reg_write_f_id", 32'(reg_write_f_id), 32'(m_ex.rw));
        chk("reg_write_f_ex", 32'(reg_write_f_ex), 32'(m_pend[1] != 0));
        chk("reg_write_f_mem", 32'(reg_write_f_mem), 32'(m_pend[2] != 0));
        chk("rs_f_id", 32'(rs_f_id), 32'(m_rs_f()));
        chk("rt_f_id", 32'(rt_f_id), 32'(m_rt_f()));
        chk("rd_f_id", 32'(rd_f_id), 32'(m_rd_f()));
        chk("id_stall", 32'(id_stall), 32'(m_stall()));
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
        chk("ex_opcode", 32'(ex_opcode), 32'(m_ex.op));
        chk("ex_rs_val", ex_rs_val, m_ex.a);
        chk("ex_rt_val", ex_rt_val, m_ex.b);
        chk("ex_imm", ex_imm, m_ex.imm);
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m_ex.rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m_ex.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m_ex.mw));
        chk("ex_pc", ex_pc, m_ex.pc);
        chk("halted", 32'(halted), 32'(m_halt));
        chk("illegal_op", 32'(illegal_op), 32'(m_ill));
        chk("instr_cnt", instr_cnt, m_icnt);
        chk("stall_cnt", stall_cnt, m_scnt);
        stall_run = id_stall ? stall_run + 1 : 0;
        chk("stall_run_le3", 32'(stall_run > 3), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        m_step();
        #1;
        compare_all();
        pc_out = pc_out + 4;
    endtask

    task automatic do_reset();
        rst = 1; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0; instruction = 32'd0;
        step();
        step();
        rst = 0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] instr;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        e_stall;
        logic        e_valid;
        logic [4:0]  e_dest;
        logic [31:0] e_icnt;
        logic [31:0] e_scnt;
        logic        e_halt;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] i, input logic f, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input logic es,
                                input logic ev, input logic [4:0] ed, input logic [31:0] ei,
                                input logic [31:0] esc, input logic eh);
        vec_t v;
        v.instr = i; v.flush = f; v.wb_en = we; v.wb_addr = wa; v.wb_data = wd;
        v.e_stall = es; v.e_valid = ev; v.e_dest = ed; v.e_icnt = ei; v.e_scnt = esc;
        v.e_halt = eh;
        return v;
    endfunction

    vec_t vecs [14];

    function automatic logic [31:0] rand_instr();
        logic [5:0]  legal_ops [17];
        logic [31:0] w;
        legal_ops = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd1, 6'd3, 6'd5, 6'd7, 6'd9,
                      6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16};
        w = $urandom;
        if ($urandom_range(0, 99) < 2) w[31:26] = 6'($urandom_range(18, 63));
        else w[31:26] = legal_ops[$urandom_range(0, 16)];
        w[25:21] = 5'($urandom_range(0, 7));
        w[20:16] = 5'($urandom_range(0, 7));
        w[15:11] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        pc_out = 32'h0000_1000;
        m_reset();

        // ADDI r5,r0,-1 / ADD r3,r1,r2 (with wb bypass of r2) / SUB r4,r3,r1 stalls 3,
        // ADDI r0 then ADD r3,r0,r0, flush during a stall, then HALT.
        vecs[0]  = mk(32'h0405FFFF, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(32'h00221800, 0, 0, 0, 0,            0, 1, 5, 1, 0, 0);
        vecs[2]  = mk(32'h08612000, 0, 1, 2, 32'h1234,     1, 1, 3, 2, 0, 0);
        vecs[3]  = mk(32'h04200007, 0, 1, 0, 32'hFFFF,     1, 0, 0, 2, 1, 0);
        vecs[4]  = mk(32'h04200007, 0, 0, 0, 0,            1, 0, 0, 2, 2, 0);
        vecs[5]  = mk(32'h04200007, 0, 0, 0, 0,            0, 0, 0, 2, 3, 0);
        vecs[6]  = mk(32'h04200007, 0, 0, 0, 0,            0, 1, 4, 3, 3, 0);
        vecs[7]  = mk(32'h00001800, 0, 0, 0, 0,            0, 1, 0, 4, 3, 0);
        vecs[8]  = mk(32'h08612000, 0, 0, 0, 0,            1, 1, 3, 5, 3, 0);
        vecs[9]  = mk(32'h04200007, 1, 0, 0, 0,            0, 0, 0, 5, 3, 0);
        vecs[10] = mk(32'h44000000, 0, 0, 0, 0,            0, 0, 0, 5, 3, 0);
        vecs[11] = mk(32'h00221800, 0, 0, 0, 0,            0, 1, 0, 6, 3, 1);
        vecs[12] = mk(32'h00221800, 0, 0, 0, 0,            0, 0, 0, 6, 3, 1);
        vecs[13] = mk(32'hFC000000, 0, 0, 0, 0,            0, 0, 0, 6, 3, 1);

        do_reset();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_instr_cnt", instr_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        for (int i = 0; i < 14; i++) begin
            instruction = vecs[i].instr;
            flush       = vecs[i].flush;
            wb_en       = vecs[i].wb_en;
            wb_addr     = vecs[i].wb_addr;
            wb_data     = vecs[i].wb_data;
            step();
            chk($sformatf("vec%0d_stall", i), 32'(id_stall), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_valid", i), 32'(ex_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_dest", i), 32'(ex_dest), 32'(vecs[i].e_dest));
            chk($sformatf("vec%0d_icnt", i), instr_cnt, vecs[i].e_icnt);
            chk($sformatf("vec%0d_scnt", i), stall_cnt, vecs[i].e_scnt);
            chk($sformatf("vec%0d_halt", i), 32'(halted), 32'(vecs[i].e_halt));
            if (i == 1) chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
            if (i == 2) chk("wb_bypass_rt", ex_rt_val, 32'h0000_1234);
            if (i == 7) chk("r0_dest_no_rw", 32'(reg_write_f_id), 32'd0);
            if (i == 8) chk("r0_reads_zero", ex_rs_val, 32'd0);
        end
        wb_en = 0;
        chk("halt_blocks_illegal", 32'(illegal_op), 32'd0);

        // undefined opcode: becomes a bubble, sticky flag, not counted
        do_reset();
        instruction = 32'hFC000000;
        step();
        instruction = 32'h00221800;
        step();
        chk("illegal_set", 32'(illegal_op), 32'd1);
        chk("illegal_not_issued", 32'(ex_valid), 32'd0);
        chk("illegal_not_counted", instr_cnt, 32'd0);
        step();
        step();
        chk("illegal_sticky", 32'(illegal_op), 32'd1);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            instruction = rand_instr();
            flush       = ($urandom_range(0, 15) == 0);
            wb_en       = 1'($urandom_range(0, 1));
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            step();
        end

        // terminate the random run with a HALT and let the scoreboard drain
        flush = 0;
        wb_en = 0;
        instruction = 32'h44000000;
        for (int c = 0; c < 8; c++) step();
        chk("random_halted", 32'(halted), 32'd1);
        instruction = 32'h00221800;
        for (int c = 0; c < 4; c++) step();
        chk("halted_no_issue", 32'(ex_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
